// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto a single req/gnt/rvalid bus.
// An ID FIFO records the owner of each outstanding transaction so responses are routed back.
module bus_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_be_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_wdata_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  output logic [DW-1:0]   m0_rdata_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_be_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            s_req_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_be_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  input  logic            s_gnt_i,
  input  logic            s_rvalid_i,
  input  logic [DW-1:0]   s_rdata_i,
  output logic            err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DEPTH-1:0] id_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             last_grant_q;
  logic             err_q;

  logic issue_ok;
  logic winner;
  logic hs;
  logic pop;
  logic head;

  // A response in the same cycle frees a slot, so a full FIFO can still issue.
  assign issue_ok = (count_q < FULL) | s_rvalid_i;
  assign winner   = m1_req_i & (~m0_req_i | ~last_grant_q);

  assign s_req_o   = rst_i & issue_ok & (m0_req_i | m1_req_i);
  assign s_we_o    = winner ? m1_we_i    : m0_we_i;
  assign s_be_o    = winner ? m1_be_i    : m0_be_i;
  assign s_addr_o  = winner ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o = winner ? m1_wdata_i : m0_wdata_i;

  assign hs       = s_req_o & s_gnt_i;
  assign m0_gnt_o = hs & ~winner;
  assign m1_gnt_o = hs & winner;

  assign pop  = rst_i & s_rvalid_i & (count_q != '0);
  assign head = id_q[rd_ptr_q];

  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      id_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      if (hs) begin
        id_q[wr_ptr_q] <= winner;
        wr_ptr_q       <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        last_grant_q   <= winner;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      if (hs && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !hs) begin
        count_q <= count_q - CW'(1);
      end
      if (s_rvalid_i && count_q == '0) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: issue checks plus an ID scoreboard
// that predicts which master each response is routed to.
module tb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i;
  logic [3:0]  m0_be_i;
  logic [31:0] m0_addr_i, m0_wdata_i;
  logic        m0_gnt_o, m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i, m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_addr_i, m1_wdata_i;
  logic        m1_gnt_o, m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic        s_req_o, s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic        s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        err_o;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  always #5 clk_i = ~clk_i;

  bus_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic r1, input logic g,
                       input logic rv, input logic [31:0] rd);
    @(negedge clk_i);
    m0_req_i   = r0;
    m1_req_i   = r1;
    s_gnt_i    = g;
    s_rvalid_i = rv;
    s_rdata_i  = rd;
    #1;
  endtask

  task automatic chk_iss(input string tag, input logic er, input logic eg0,
                         input logic eg1, input logic [31:0] ea);
    chk({tag, "_req"}, 64'(s_req_o), 64'(er));
    chk({tag, "_gnt0"}, 64'(m0_gnt_o), 64'(eg0));
    chk({tag, "_gnt1"}, 64'(m1_gnt_o), 64'(eg1));
    if (er) begin
      chk({tag, "_addr"}, 64'(s_addr_o), 64'(ea));
      chk({tag, "_we"}, 64'(s_we_o), 64'(ea == 32'h200));
    end
    if (eg0) exp_q.push_back(1'b0);
    if (eg1) exp_q.push_back(1'b1);
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] rd);
    bit id;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed response expected none outstanding", tag);
    end else begin
      id = exp_q.pop_front();
      chk({tag, "_rv0"}, 64'(m0_rvalid_o), 64'(id == 1'b0));
      chk({tag, "_rv1"}, 64'(m1_rvalid_o), 64'(id == 1'b1));
      chk({tag, "_rd"}, 64'(id ? m1_rdata_o : m0_rdata_o), 64'(rd));
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    m0_req_i = 1'b1; m1_req_i = 1'b1;
    s_gnt_i = 1'b1; s_rvalid_i = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_req", 64'(s_req_o), 64'd0);
    chk("rst_gnt", 64'({m0_gnt_o, m1_gnt_o}), 64'd0);
    chk("rst_rv", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = 32'h1111_0000;
    m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = 32'h2222_0000;
    m0_addr_i = 32'h0000_0010; m1_addr_i = 32'h200;
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    #2;
    do_reset();

    // single master read
    drive(1, 0, 1, 0, 0);
    chk_iss("t1_iss", 1, 1, 0, 32'h10);
    chk("t1_be", 64'(s_be_o), 64'hF);
    chk("t1_rv1_idle", 64'(m1_rvalid_o), 64'd0);
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk_rsp("t1_rsp", 32'hDEAD_BEEF);
    chk("t1_err", 64'(err_o), 64'd0);

    // contention, 1-cycle bus
    do_reset();
    m0_addr_i = 32'h100;
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1, i > 0, 32'hA000 + 32'(i));
      if (i > 0) chk_rsp("ct_rsp", 32'hA000 + 32'(i));
      chk_iss("ct_iss", 1, (i % 2) == 0, (i % 2) == 1,
              (i % 2) == 1 ? 32'h200 : 32'h100);
    end
    drive(0, 0, 0, 1, 32'hA006);
    chk_rsp("ct_last", 32'hA006);

    // backpressure
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0);
      chk_iss("bp_hold", 1, 0, 0, 32'h100);
    end
    drive(1, 1, 1, 0, 0);
    chk_iss("bp_win", 1, 1, 0, 32'h100);
    drive(1, 1, 1, 1, 32'hB001);
    chk_rsp("bp_rsp0", 32'hB001);
    chk_iss("bp_next", 1, 0, 1, 32'h200);
    drive(0, 0, 0, 1, 32'hB002);
    chk_rsp("bp_rsp1", 32'hB002);

    // full FIFO
    do_reset();
    drive(1, 0, 1, 0, 0);
    chk_iss("fu_g0", 1, 1, 0, 32'h100);
    drive(1, 1, 1, 0, 0);
    chk_iss("fu_g1", 1, 0, 1, 32'h200);
    drive(1, 1, 1, 0, 0);
    chk_iss("fu_full", 0, 0, 0, 0);
    drive(1, 1, 1, 1, 32'hC001);
    chk_rsp("fu_pop", 32'hC001);
    chk_iss("fu_pushpop", 1, 1, 0, 32'h100);
    drive(1, 1, 1, 0, 0);
    chk_iss("fu_still", 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'hC002);
    chk_rsp("fu_drain1", 32'hC002);
    drive(0, 0, 0, 1, 32'hC003);
    chk_rsp("fu_drain0", 32'hC003);

    // spurious response on empty FIFO
    drive(0, 0, 0, 1, 32'hC004);
    chk("sp_rv", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
    chk("sp_err_pre", 64'(err_o), 64'd0);
    drive(0, 0, 0, 0, 0);
    chk("sp_err_set", 64'(err_o), 64'd1);
    drive(1, 0, 0, 0, 0);
    chk("sp_err_hold", 64'(err_o), 64'd1);

    // async reset with outstanding transactions
    do_reset();
    drive(1, 0, 1, 0, 0);
    chk_iss("ar_g0", 1, 1, 0, 32'h100);
    drive(0, 1, 1, 0, 0);
    chk_iss("ar_g1", 1, 0, 1, 32'h200);
    drive(1, 1, 1, 1, 32'hD000);
    chk("ar_pre_rv0", 64'(m0_rvalid_o), 64'd1);
    chk("ar_pre_req", 64'(s_req_o), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("ar_req", 64'(s_req_o), 64'd0);
    chk("ar_gnt", 64'({m0_gnt_o, m1_gnt_o}), 64'd0);
    chk("ar_rv", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
    exp_q.delete();
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(0, 0, 0, 1, 32'hD001);
    chk("ar_stray_rv", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
    drive(1, 1, 1, 0, 0);
    chk("ar_err", 64'(err_o), 64'd1);
    chk_iss("ar_tie", 1, 1, 0, 32'h100);
    drive(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
